// File: rtl/mem_access_if.sv
// mem_access_if: data-bus handshake between the MEM stage and the data memory.
//
// Handshake (valid/ready style):
//   The master raises data_req and holds data_addr/data_wr/data_wdata/data_wstrb
//   stable until the slave answers with data_gnt in the same cycle. The request
//   is then considered accepted and data_req drops. A later (or the same) cycle
//   with data_resp=1 completes the access; data_rdata is valid only in that
//   cycle. data_resp with no outstanding accepted request is ignored.
//
// Signals:
//   data_req   master->slave  request valid
//   data_wr    master->slave  1 = store, 0 = load
//   data_addr  master->slave  word-aligned byte address
//   data_wdata master->slave  byte-lane replicated store data
//   data_wstrb master->slave  byte enables (0000 for loads)
//   data_gnt   slave->master  request accepted
//   data_resp  slave->master  access completed
//   data_rdata slave->master  load data (whole word)
interface mem_access_if;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_gnt;
    logic        data_resp;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_addr, data_wdata, data_wstrb,
        input  data_gnt, data_resp, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_addr, data_wdata, data_wstrb,
        output data_gnt, data_resp, data_rdata
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with a stalling data-bus access FSM.
//
// Non-memory instructions pass straight through to MEM/WB with no latency.
// Aligned loads/stores freeze the upstream pipeline (stall_req) while the
// bus access runs through IDLE -> REQ -> [WAIT] -> DONE. Misaligned accesses
// are rejected in IDLE with addr_err. An access that spends TIMEOUT cycles in
// REQ/WAIT is abandoned and finishes in DONE with bus_err and no writeback.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, mem_op    instruction valid and memory operation code
//   mem_addr            byte address, mem_store_data raw rt value
//   mem_alu_result, mem_reg_addr_in, mem_reg_en_in   EX result / reg target
//   mem_hi_in, mem_lo_in, mem_hilo_en_in             HI/LO writeback
//   mem_reg_write_*, mem_hi/lo_write_data, mem_hilo_write_en  to MEM/WB
//   stall_req           freeze PC, IF/ID, ID/EX, EX/MEM
//   bus                 data bus (master side)
//   addr_err, bus_err   misaligned access / bus timeout flags
//   dbg_state           current FSM state
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    input  logic [31:0] mem_alu_result,
    input  logic [4:0]  mem_reg_addr_in,
    input  logic        mem_reg_en_in,
    input  logic [31:0] mem_hi_in,
    input  logic [31:0] mem_lo_in,
    input  logic        mem_hilo_en_in,
    output logic [31:0] mem_reg_write_data,
    output logic [4:0]  mem_reg_write_addr,
    output logic        mem_reg_write_en,
    output logic [31:0] mem_hi_write_data,
    output logic [31:0] mem_lo_write_data,
    output logic        mem_hilo_write_en,
    output logic        stall_req,
    mem_access_if.master bus,
    output logic        addr_err,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] { IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3 } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          data_req_q;
    logic          bus_err_q;

    logic        is_load, is_store, is_mem, misaligned, start, timeout_hit;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign is_load     = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    assign is_store    = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    assign is_mem      = is_load || is_store;
    assign misaligned  = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0]) ||
                         (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00));
    assign start       = in_valid && is_mem && !misaligned;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata_q    <= '0;
            data_req_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        cnt        <= '0;
                        data_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    // A response without grant is stray and ignored here.
                    if (bus.data_gnt && bus.data_resp) begin
                        state      <= DONE;
                        rdata_q    <= bus.data_rdata;
                        data_req_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state      <= DONE;
                        bus_err_q  <= 1'b1;
                        data_req_q <= 1'b0;
                    end else if (bus.data_gnt) begin
                        state      <= WAIT;
                        data_req_q <= 1'b0;
                        cnt        <= cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.data_resp) begin
                        state   <= DONE;
                        rdata_q <= bus.data_rdata;
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane extraction from the captured word; mem_addr/mem_op are still held
    // by the frozen upstream stage during DONE.
    always_comb begin
        lane_half = mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_addr[1:0])
            2'd0:    lane_byte = rdata_q[7:0];
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            default: lane_byte = rdata_q[31:24];
        endcase
        case (mem_op)
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'd0, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'd0, lane_half};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        bus.data_req  = data_req_q;
        bus.data_wr   = is_store;
        bus.data_addr = {mem_addr[31:2], 2'b00};
        case (mem_op)
            OP_SB: begin
                bus.data_wdata = {4{mem_store_data[7:0]}};
                bus.data_wstrb = 4'b0001 << mem_addr[1:0];
            end
            OP_SH: begin
                bus.data_wdata = {2{mem_store_data[15:0]}};
                bus.data_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                bus.data_wdata = mem_store_data;
                bus.data_wstrb = 4'b1111;
            end
            default: begin
                bus.data_wdata = mem_store_data;
                bus.data_wstrb = 4'b0000;
            end
        endcase
    end

    // stall_req and addr_err are combinational in IDLE, so they are gated by
    // rst to stay low while reset is held.
    always_comb begin
        mem_reg_write_data = mem_alu_result;
        mem_reg_write_addr = mem_reg_addr_in;
        mem_reg_write_en   = mem_reg_en_in;
        mem_hi_write_data  = mem_hi_in;
        mem_lo_write_data  = mem_lo_in;
        mem_hilo_write_en  = mem_hilo_en_in;
        stall_req          = 1'b0;
        addr_err           = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && is_mem) begin
                    mem_reg_write_en = 1'b0;
                    if (misaligned) begin
                        addr_err = rst;
                    end else begin
                        stall_req         = rst;
                        mem_hilo_write_en = 1'b0;
                    end
                end
            end
            REQ, WAIT: begin
                stall_req         = 1'b1;
                mem_reg_write_en  = 1'b0;
                mem_hilo_write_en = 1'b0;
            end
            default: begin
                if (bus_err_q) begin
                    mem_reg_write_en  = 1'b0;
                    mem_hilo_write_en = 1'b0;
                end else if (is_load) begin
                    mem_reg_write_data = load_data;
                end else begin
                    mem_reg_write_en = 1'b0;
                end
            end
        endcase
    end

    assign bus_err   = bus_err_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    localparam int TO = 4;

    logic        clk, rst;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_store_data, mem_alu_result;
    logic [4:0]  mem_reg_addr_in;
    logic        mem_reg_en_in;
    logic [31:0] mem_hi_in, mem_lo_in;
    logic        mem_hilo_en_in;
    logic [31:0] mem_reg_write_data;
    logic [4:0]  mem_reg_write_addr;
    logic        mem_reg_write_en;
    logic [31:0] mem_hi_write_data, mem_lo_write_data;
    logic        mem_hilo_write_en;
    logic        stall_req, addr_err, bus_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    mem_access_if bus_if();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .mem_alu_result(mem_alu_result), .mem_reg_addr_in(mem_reg_addr_in),
        .mem_reg_en_in(mem_reg_en_in), .mem_hi_in(mem_hi_in), .mem_lo_in(mem_lo_in),
        .mem_hilo_en_in(mem_hilo_en_in), .mem_reg_write_data(mem_reg_write_data),
        .mem_reg_write_addr(mem_reg_write_addr), .mem_reg_write_en(mem_reg_write_en),
        .mem_hi_write_data(mem_hi_write_data), .mem_lo_write_data(mem_lo_write_data),
        .mem_hilo_write_en(mem_hilo_write_en), .stall_req(stall_req), .bus(bus_if),
        .addr_err(addr_err), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (from the op rules) ----------------
    function automatic bit m_is_load(input logic [3:0] op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return (op >= 6) && (op <= 8);
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, rd);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(addr % 4);
        case (op)
            4'd1, 4'd2: begin
                v = (rd >> sh) % 256;
                if (op == 4'd1 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            4'd3, 4'd4: begin
                v = (rd >> ((addr % 4 >= 2) ? 16 : 0)) % 65536;
                if (op == 4'd3 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'd6:    return 4'(1 << (addr % 4));
            4'd7:    return (addr % 4 >= 2) ? 4'd12 : 4'd3;
            4'd8:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] rt);
        case (op)
            4'd6:    return (rt % 256) * 32'h0101_0101;
            4'd7:    return (rt % 65536) * 32'h0001_0001;
            default: return rt;
        endcase
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive_instr(input logic v, input logic [3:0] op, input logic [31:0] addr, rt,
                               alu, input logic [4:0] ra, input logic en);
        in_valid        = v;
        mem_op          = op;
        mem_addr        = addr;
        mem_store_data  = rt;
        mem_alu_result  = alu;
        mem_reg_addr_in = ra;
        mem_reg_en_in   = en;
        mem_hi_in       = $urandom;
        mem_lo_in       = $urandom;
        mem_hilo_en_in  = 1'b0;
    endtask

    task automatic drive_bus(input logic gnt, resp, input logic [31:0] rd);
        bus_if.data_gnt   = gnt;
        bus_if.data_resp  = resp;
        bus_if.data_rdata = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 32'd0);
        drive_instr(1'b1, 4'd5, 32'h0000_0101, 32'd0, 32'd0, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        total++; if (bus_if.data_req !== 1'b0) begin bad++; $display("FAIL reset_data_req got=%b exp=0", bus_if.data_req); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        drive_instr(1'b1, 4'd8, 32'h0000_0100, 32'd0, 32'd0, 5'd0, 1'b1);
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        drive_instr(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [31:0] alu;
        logic [4:0]  ra;
        logic        en, v, he;
        logic [3:0]  op;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                v = 1'b1; op = 4'd0; alu = 32'h1234; ra = 5'd5; en = 1'b1; he = 1'b0;
            end else begin
                v   = 1'($urandom_range(0, 1));
                op  = v ? ((i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15))) : 4'($urandom_range(0, 15));
                alu = $urandom; ra = 5'($urandom); en = 1'($urandom); he = 1'($urandom);
            end
            drive_instr(v, op, $urandom, $urandom, alu, ra, en);
            mem_hilo_en_in = he;
            drive_bus(1'b0, 1'b0, 32'd0);
            @(negedge clk);
            total++; if (mem_reg_write_data !== alu) begin bad++; $display("FAIL pass_data[%0d] got=%h exp=%h", i, mem_reg_write_data, alu); end
            total++; if (mem_reg_write_addr !== ra || mem_reg_write_en !== en) begin bad++;
                $display("FAIL pass_reg[%0d] got=%0d/%b exp=%0d/%b", i, mem_reg_write_addr, mem_reg_write_en, ra, en); end
            total++; if (mem_hi_write_data !== mem_hi_in || mem_lo_write_data !== mem_lo_in || mem_hilo_write_en !== he) begin bad++;
                $display("FAIL pass_hilo[%0d] got=%h/%h/%b exp=%h/%h/%b", i, mem_hi_write_data, mem_lo_write_data,
                         mem_hilo_write_en, mem_hi_in, mem_lo_in, he); end
            total++; if (stall_req !== 1'b0 || bus_if.data_req !== 1'b0 || addr_err !== 1'b0) begin bad++;
                $display("FAIL pass_ctrl[%0d] got stall=%b req=%b aerr=%b exp 0/0/0", i, stall_req, bus_if.data_req, addr_err); end
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                op = 4'd5; addr = 32'h0000_0101;
            end else begin
                case ($urandom_range(0, 4))
                    0: op = 4'd3;
                    1: op = 4'd4;
                    2: op = 4'd7;
                    3: op = 4'd5;
                    default: op = 4'd8;
                endcase
                addr = $urandom;
                if (op == 4'd5 || op == 4'd8) addr = {addr[31:2], 2'($urandom_range(1, 3))};
                else addr[0] = 1'b1;
            end
            drive_instr(1'b1, op, addr, $urandom, $urandom, 5'($urandom), 1'b1);
            drive_bus(1'b0, 1'b0, 32'd0);
            @(negedge clk);
            total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL mis_addr_err[%0d] op=%0d addr=%h got=%b exp=1", i, op, addr, addr_err); end
            total++; if (mem_reg_write_en !== 1'b0 || stall_req !== 1'b0 || bus_if.data_req !== 1'b0) begin bad++;
                $display("FAIL mis_ctrl[%0d] got en=%b stall=%b req=%b exp 0/0/0", i, mem_reg_write_en, stall_req, bus_if.data_req); end
            @(posedge clk); #1;
            drive_instr(1'b0, 4'd0, 32'd0, 32'd0, 32'h55, 5'd1, 1'b1);
            @(negedge clk);
            total++; if (bus_if.data_req !== 1'b0 || stall_req !== 1'b0 || mem_reg_write_en !== 1'b1 || addr_err !== 1'b0) begin bad++;
                $display("FAIL mis_after[%0d] got req=%b stall=%b en=%b aerr=%b exp 0/0/1/0", i, bus_if.data_req, stall_req,
                         mem_reg_write_en, addr_err); end
        end
    endtask

    // One full access: grant after g extra REQ cycles, response r cycles after
    // grant (0 = same cycle). noise drives stray responses before the grant.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, rt, rd,
                             input int g, r, input bit noise, input string tag);
        logic [31:0] alu;
        logic [4:0]  ra;
        logic        en, exp_req;
        int          d, stalls;
        alu = $urandom; ra = 5'($urandom); en = 1'($urandom_range(0, 1));
        d = g + r + 2;
        stalls = 0;
        for (int c = 0; c <= d; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_instr(1'b1, op, addr, rt, alu, ra, en);
            drive_bus(c == g + 1, (c == g + 1 + r) || (noise && c < g + 1), (c == g + 1 + r) ? rd : $urandom);
            @(negedge clk);
            stalls += int'(stall_req);
            exp_req = (c >= 1) && (c <= g + 1);
            total++; if (bus_if.data_req !== exp_req) begin bad++;
                $display("FAIL %s data_req c=%0d got=%b exp=%b", tag, c, bus_if.data_req, exp_req); end
            if (exp_req) begin
                total++; if (bus_if.data_addr !== addr - (addr % 4) || bus_if.data_wr !== m_is_store(op) ||
                             bus_if.data_wstrb !== m_wstrb(op, addr)) begin bad++;
                    $display("FAIL %s bus_req c=%0d got addr=%h wr=%b strb=%b exp addr=%h wr=%b strb=%b", tag, c,
                             bus_if.data_addr, bus_if.data_wr, bus_if.data_wstrb, addr - (addr % 4), m_is_store(op),
                             m_wstrb(op, addr)); end
                if (m_is_store(op)) begin
                    total++; if (bus_if.data_wdata !== m_wdata(op, rt)) begin bad++;
                        $display("FAIL %s wdata got=%h exp=%h", tag, bus_if.data_wdata, m_wdata(op, rt)); end
                end
            end
            if (c < d) begin
                total++; if (mem_reg_write_en !== 1'b0 || mem_hilo_write_en !== 1'b0 || addr_err !== 1'b0) begin bad++;
                    $display("FAIL %s bubble c=%0d got en=%b hilo=%b aerr=%b exp 0/0/0", tag, c, mem_reg_write_en,
                             mem_hilo_write_en, addr_err); end
            end else begin
                total++; if (stall_req !== 1'b0 || bus_err !== 1'b0) begin bad++;
                    $display("FAIL %s done_ctrl got stall=%b berr=%b exp 0/0", tag, stall_req, bus_err); end
                total++; if (mem_reg_write_en !== (m_is_load(op) ? en : 1'b0) || mem_reg_write_addr !== ra) begin bad++;
                    $display("FAIL %s done_en got en=%b addr=%0d exp en=%b addr=%0d", tag, mem_reg_write_en,
                             mem_reg_write_addr, m_is_load(op) ? en : 1'b0, ra); end
                if (m_is_load(op)) begin
                    total++; if (mem_reg_write_data !== m_load(op, addr, rd)) begin bad++;
                        $display("FAIL %s load_data got=%h exp=%h", tag, mem_reg_write_data, m_load(op, addr, rd)); end
                end
            end
        end
        total++; if (stalls != d) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, stalls, d); end
    endtask

    task automatic test_directed_access();
        do_access(4'd1, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 1, 1'b0, "lb_0x103");
        do_access(4'd7, 32'h0000_0202, 32'hAAAA_BEEF, 32'd0, 0, 0, 1'b0, "sh_0x202");
    endtask

    task automatic test_random_access();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            op   = 4'($urandom_range(1, 8));
            addr = $urandom;
            if (op == 4'd3 || op == 4'd4 || op == 4'd7) addr[0] = 1'b0;
            if (op == 4'd5 || op == 4'd8) addr[1:0] = 2'b00;
            do_access(op, addr, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                      1'($urandom_range(0, 1)), "rand_acc");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] alu;
        do_access(4'd5, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 0, 0, 1'b0, "b2b_lw");
        do_access(4'd8, 32'h0000_0044, 32'h1357_9BDF, 32'd0, 1, 0, 1'b0, "b2b_sw");
        @(posedge clk); #1;
        alu = $urandom;
        drive_instr(1'b1, 4'd0, 32'd0, 32'd0, alu, 5'd9, 1'b1);
        drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        total++; if (mem_reg_write_data !== alu || mem_reg_write_en !== 1'b1 || stall_req !== 1'b0) begin bad++;
            $display("FAIL b2b_pass got data=%h en=%b stall=%b exp data=%h en=1 stall=0", mem_reg_write_data,
                     mem_reg_write_en, stall_req, alu); end
    endtask

    // gnt_at = 0: never granted (times out in REQ); otherwise granted in that
    // cycle and then times out in WAIT.
    task automatic test_timeout(input int gnt_at);
        logic [31:0] alu;
        logic        exp_req;
        for (int c = 0; c <= TO + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_instr(1'b1, 4'd5, 32'h0000_0400, 32'd0, 32'd0, 5'd3, 1'b1);
            drive_bus(c == gnt_at, 1'b0, 32'd0);
            @(negedge clk);
            if (c <= TO) begin
                exp_req = (c >= 1) && ((gnt_at == 0) || (c <= gnt_at));
                total++; if (stall_req !== 1'b1 || bus_err !== 1'b0 || mem_reg_write_en !== 1'b0 ||
                             bus_if.data_req !== exp_req) begin bad++;
                    $display("FAIL to%0d wait c=%0d got stall=%b berr=%b en=%b req=%b exp 1/0/0/%b", gnt_at, c,
                             stall_req, bus_err, mem_reg_write_en, bus_if.data_req, exp_req); end
            end else begin
                total++; if (bus_err !== 1'b1 || mem_reg_write_en !== 1'b0 || mem_hilo_write_en !== 1'b0 ||
                             stall_req !== 1'b0 || bus_if.data_req !== 1'b0) begin bad++;
                    $display("FAIL to%0d done got berr=%b en=%b hilo=%b stall=%b req=%b exp 1/0/0/0/0", gnt_at,
                             bus_err, mem_reg_write_en, mem_hilo_write_en, stall_req, bus_if.data_req); end
            end
        end
        @(posedge clk); #1;
        alu = $urandom;
        drive_instr(1'b0, 4'd0, 32'd0, 32'd0, alu, 5'd4, 1'b1);
        @(negedge clk);
        total++; if (bus_err !== 1'b0 || mem_reg_write_en !== 1'b1 || mem_reg_write_data !== alu || stall_req !== 1'b0) begin bad++;
            $display("FAIL to%0d idle got berr=%b en=%b data=%h stall=%b exp 0/1/%h/0", gnt_at, bus_err,
                     mem_reg_write_en, mem_reg_write_data, stall_req, alu); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] alu;
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_instr(1'b1, 4'd5, 32'h0000_0500, 32'd0, 32'd0, 5'd7, 1'b1);
            drive_bus(c == 1, 1'b0, 32'd0);
            @(negedge clk);
        end
        total++; if (stall_req !== 1'b1 || bus_if.data_req !== 1'b0) begin bad++;
            $display("FAIL rmid pre got stall=%b req=%b exp 1/0", stall_req, bus_if.data_req); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus_if.data_req !== 1'b0 || stall_req !== 1'b0 || bus_err !== 1'b0 || addr_err !== 1'b0) begin bad++;
            $display("FAIL rmid async got req=%b stall=%b berr=%b aerr=%b exp 0/0/0/0", bus_if.data_req, stall_req,
                     bus_err, addr_err); end
        @(posedge clk); #1;
        total++; if (bus_if.data_req !== 1'b0 || stall_req !== 1'b0) begin bad++;
            $display("FAIL rmid held got req=%b stall=%b exp 0/0", bus_if.data_req, stall_req); end
        @(negedge clk); #2;
        alu = $urandom;
        drive_instr(1'b0, 4'd0, 32'd0, 32'd0, alu, 5'd7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        total++; if (bus_if.data_req !== 1'b0 || stall_req !== 1'b0 || mem_reg_write_en !== 1'b0 ||
                     mem_reg_write_data !== alu || bus_err !== 1'b0) begin bad++;
            $display("FAIL rmid late_resp got req=%b stall=%b en=%b data=%h berr=%b exp 0/0/0/%h/0", bus_if.data_req,
                     stall_req, mem_reg_write_en, mem_reg_write_data, bus_err, alu); end
        @(posedge clk); #1;
        drive_bus(1'b0, 1'b0, 32'd0);
        drive_instr(1'b0, 4'd0, 32'd0, 32'd0, alu, 5'd7, 1'b1);
        @(negedge clk);
        total++; if (bus_err !== 1'b0 || mem_reg_write_en !== 1'b1 || mem_reg_write_data !== alu || stall_req !== 1'b0) begin bad++;
            $display("FAIL rmid after got berr=%b en=%b data=%h stall=%b exp 0/1/%h/0", bus_err, mem_reg_write_en,
                     mem_reg_write_data, stall_req, alu); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_misaligned();
        test_directed_access();
        test_random_access();
        test_back_to_back();
        test_timeout(0);
        test_timeout(1);
        test_reset_mid();
        do_access(4'd2, 32'h0000_0601, 32'd0, 32'h1122_8344, 1, 1, 1'b1, "post_reset_lbu");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
